// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: packs 4 bytes per word and writes them to sequential addresses.
// Optional running checksum of written words is enabled by defining LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int ADDR_W     = 10,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] a,
    output logic [31:0]       d,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum,
    output logic [1:0]        dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready depends only on state.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_words_left;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_a;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_asm;
    logic [31:0]       r_d;

    logic              w_xfer;
    logic              w_start_ok;
    logic              w_last_word;
    logic [ADDR_W:0]   w_len_eff;
    logic [31:0]       w_asm_next;

    assign w_xfer      = (r_state == S_COLLECT) && in_valid;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_len_eff   = (len > MAX_WORDS) ? MAX_WORDS : len;
    assign w_last_word = (r_words_left == CNT_ONE);
    assign w_asm_next  = (BIG_ENDIAN != 0) ? {r_asm[23:0], in_data} : {in_data, r_asm[31:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_words_left <= '0;
            r_idx        <= '0;
            r_a          <= '0;
            r_byte_cnt   <= '0;
            r_asm        <= '0;
            r_d          <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_words_left <= w_len_eff;
                        r_idx        <= '0;
                        r_byte_cnt   <= '0;
                        r_asm        <= '0;
                        r_state      <= (w_len_eff == '0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_asm      <= w_asm_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_a     <= r_idx;
                            r_d     <= w_asm_next;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // Index only advances when another word follows, so a full-depth load never wraps it.
                    if (w_last_word) begin
                        r_state <= S_DONE;
                    end else begin
                        r_words_left <= r_words_left - CNT_ONE;
                        r_idx        <= r_idx + IDX_ONE;
                        r_state      <= S_COLLECT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_COLLECT);
    assign we        = (r_state == S_WRITE);
    assign busy      = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign a         = r_a;
    assign d         = r_d;
    assign dbg_state = r_state;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (r_state == S_WRITE) begin
            r_checksum <= r_checksum + r_d;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the instruction memory (depth 2^ADDR_W words).
REQ-002 Parameter BIG_ENDIAN, default 1; 1 = first byte received lands in d[31:24], 0 = first byte lands in d[7:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
REQ-006 len  input  ADDR_W+1  number of 32-bit words to load, sampled on start.
REQ-007 in_data  input  8  program byte stream.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts the byte this cycle; a byte transfers when in_valid and in_ready are both high.
REQ-010 a  output  ADDR_W  memory write address.
REQ-011 d  output  32  memory write data.
REQ-012 we  output  1  memory write enable, one-cycle pulse per word.
REQ-013 busy  output  1  high from the cycle after an accepted start until the last write completes; the CPU is held in reset while busy.
REQ-014 done  output  1  high after a load completes; held until the next accepted start or rst.
REQ-015 checksum  output  32  running sum of written words (see Configuration).

Function
REQ-016 States: IDLE, COLLECT, WRITE, DONE.
REQ-017 IDLE/DONE + start: latch min(len, 2^ADDR_W) into a word counter, clear the word index to 0, clear the byte counter, clear done, go to COLLECT; if the latched length is 0, go directly to DONE with done=1 and no write.
REQ-018 COLLECT: in_ready=1; each transfer shifts the byte into the assembly register per BIG_ENDIAN and increments the 2-bit byte counter; on the 4th transfer go to WRITE.
REQ-019 WRITE: we=1 for exactly one cycle, a=word index, d=assembled word, in_ready=0; the next state is COLLECT if words remain, else DONE.
REQ-020 Latency: we is asserted the cycle immediately after the 4th byte transfer; minimum of 5 cycles per word.
REQ-021 The word index increments by 1 after each write; at len=2^ADDR_W the last write uses address 2^ADDR_W-1 and the index never wraps to 0 during a load.
REQ-022 in_ready=0 in IDLE, WRITE and DONE; bytes presented there are not consumed.
REQ-023 A start asserted while busy is ignored.
REQ-024 busy=1 in COLLECT and WRITE only; done=1 in DONE only.
REQ-025 a and d hold their last driven values when we=0; the memory ignores them then.

Reset
REQ-026 rst asserts asynchronously: state=IDLE, we=0, in_ready=0, busy=0, done=0, a=0, d=0, checksum=0, and all counters are 0.
REQ-027 rst during COLLECT or WRITE aborts the load immediately; a partially assembled word is discarded and no write occurs after rst asserts.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: checksum clears on an accepted start and adds d (modulo 2^32) on every cycle with we=1.
REQ-029 LOADER_CHECKSUM_EN undefined: checksum is tied to 0 and no adder is synthesised.

Verification
REQ-030 len=1, bytes 0x12,0x34,0x56,0x78 with in_valid held high, BIG_ENDIAN=1 -> a single we pulse with a=0, d=0x12345678, one cycle after the 4th byte; then done=1, busy=0.
REQ-031 Same stimulus with BIG_ENDIAN=0 -> d=0x78563412.
REQ-032 len=3, in_valid toggling 1/0 every cycle, words 0x00000001, 0x00000002, 0x00000003 -> writes to a=0,1,2 in order, with exactly 3 we pulses; with LOADER_CHECKSUM_EN, checksum=0x00000006.
REQ-033 len=0 start -> done=1 on the next cycle, no we, in_ready stays 0.
REQ-034 len=2, rst pulsed after the 6th byte -> no second write, all outputs return to their reset values, and a subsequent start with len=1 loads to a=0 correctly.
REQ-035 len=1024 (ADDR_W=10); start pulsed again mid-load -> the second start is ignored, the last write has a=0x3FF, and exactly 1024 we pulses occur.
